// File: rtl/sram_port0_ctrl.sv
// Single-port SRAM front end: serialises byte-masked writes, two-cycle reads
// and a whole-array zero-fill onto the registered port-0 pins of the macro.
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_WMASKS-1:0]   req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    clear_start,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ADDR_WIDTH-1:0]   req_word;
  logic                    unused_byte_offset;

  // Requests are word-aligned; the byte offset carries no information here.
  assign req_word           = req_addr[ADDR_WIDTH+1:2];
  assign unused_byte_offset = ^req_addr[1:0];

  // A pending clear wins over a simultaneous request, so refuse it up front.
  assign req_ready = (state == IDLE) && !clear_start;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      clear_done  <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          sram_csb0   <= 1'b1;
          sram_web0   <= 1'b1;
          sram_wmask0 <= '0;
          if (clear_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (req_valid) begin
            sram_csb0  <= 1'b0;
            sram_addr0 <= req_word;
            if (req_we) begin
              sram_web0   <= 1'b0;
              sram_wmask0 <= req_be;
              sram_din0   <= req_wdata;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Macro latches the read on this edge; data is valid before the next.
          sram_csb0   <= 1'b1;
          sram_web0   <= 1'b1;
          sram_wmask0 <= '0;
          state       <= RD_CAP;
        end
        RD_CAP: begin
          sram_csb0   <= 1'b1;
          sram_web0   <= 1'b1;
          sram_wmask0 <= '0;
          rsp_rdata   <= sram_dout0;
          rsp_valid   <= 1'b1;
          state       <= IDLE;
        end
        CLEAR: begin
          sram_csb0   <= 1'b0;
          sram_web0   <= 1'b0;
          sram_wmask0 <= '1;
          sram_addr0  <= clr_cnt;
          sram_din0   <= '0;
          // Stop on the last word rather than letting the counter wrap.
          if (clr_cnt == LAST_ADDR) begin
            clear_done <= 1'b1;
            state      <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: behavioural SRAM macro, schedule-based reference
// model compared every cycle, directed scenarios and a randomized phase.
module tb_sram_port0_ctrl;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int NW    = 4;
  localparam int WORDS = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW+1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NW-1:0] req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start;
  logic          busy;
  logic          clear_done;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  int checks = 0;
  int errors = 0;

  sram_port0_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural macro: commands sampled at posedge, read data after a 2-unit delay.
  logic [DW-1:0] sram_mem [WORDS];
  logic          sram_init = 1'b0;
  logic [AW-1:0] rd_word;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] = init_word(i);
      sram_init = 1'b1;
    end
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < NW; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] = sram_din0[8*b +: 8];
      end else begin
        rd_word = sram_addr0;
        #2;
        sram_dout0 = sram_mem[rd_word];
      end
    end
  end

  // Reference model: expected memory plus cycle-number schedules of busy windows.
  logic [DW-1:0] ref_mem [WORDS];
  int            cyc = 0;
  int            rd_end = -10;
  int            clr_cyc = -10000;
  int            clr_end = -10;
  logic [DW-1:0] rd_data;
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic [NW-1:0] pend_be;
  logic          m_idle;
  logic [AW-1:0] wa;
  logic          exp_csb = 1'b1, exp_web = 1'b1, exp_rsp_valid = 1'b0, exp_done = 1'b0;
  logic [NW-1:0] exp_wmask = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0, exp_rdata = '0;

  always @(negedge clk) begin
    if (cyc == 0)
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    if (!rst_n) begin
      exp_csb = 1'b1; exp_web = 1'b1; exp_wmask = '0; exp_addr = '0; exp_din = '0;
      exp_rsp_valid = 1'b0; exp_rdata = '0; exp_done = 1'b0;
      rd_end = -10; clr_end = -10; clr_cyc = -10000; pend_v = 1'b0;
    end
    check("sram_csb0",   64'(sram_csb0),   64'(exp_csb));
    check("sram_web0",   64'(sram_web0),   64'(exp_web));
    check("sram_wmask0", 64'(sram_wmask0), 64'(exp_wmask));
    check("sram_addr0",  64'(sram_addr0),  64'(exp_addr));
    check("sram_din0",   64'(sram_din0),   64'(exp_din));
    check("rsp_valid",   64'(rsp_valid),   64'(exp_rsp_valid));
    check("rsp_rdata",   64'(rsp_rdata),   64'(exp_rdata));
    check("clear_done",  64'(clear_done),  64'(exp_done));
    if (!rst_n) begin
      check("req_ready_rst", 64'(req_ready), 64'(!clear_start));
      check("busy_rst",      64'(busy),      64'(0));
    end else begin
      // A write issued on the previous edge lands in the macro on the coming edge.
      if (pend_v)
        for (int b = 0; b < NW; b++)
          if (pend_be[b]) ref_mem[pend_a][8*b +: 8] = pend_d[8*b +: 8];
      pend_v = 1'b0;
      m_idle = !(cyc <= rd_end) && !(cyc <= clr_end);
      check("req_ready", 64'(req_ready), 64'(m_idle && !clear_start));
      check("busy",      64'(busy),      64'(!m_idle));
      exp_rsp_valid = 1'b0;
      exp_done      = 1'b0;
      if (m_idle) begin
        exp_csb = 1'b1; exp_web = 1'b1; exp_wmask = '0;
        if (clear_start) begin
          clr_cyc = cyc;
          clr_end = cyc + WORDS;
        end else if (req_valid) begin
          wa = req_addr[AW+1:2];
          exp_csb  = 1'b0;
          exp_addr = wa;
          if (req_we) begin
            exp_web = 1'b0; exp_wmask = req_be; exp_din = req_wdata;
            pend_v = 1'b1; pend_a = wa; pend_d = req_wdata; pend_be = req_be;
          end else begin
            rd_end  = cyc + 2;
            rd_data = ref_mem[wa];
          end
        end
      end else if (cyc <= clr_end) begin
        exp_csb = 1'b0; exp_web = 1'b0; exp_wmask = '1;
        exp_addr = AW'(cyc - clr_cyc - 1);
        exp_din  = '0;
        pend_v = 1'b1; pend_a = exp_addr; pend_d = '0; pend_be = '1;
        if (cyc == clr_end) exp_done = 1'b1;
      end else begin
        exp_csb = 1'b1; exp_web = 1'b1; exp_wmask = '0;
        if (cyc == rd_end) begin
          exp_rsp_valid = 1'b1;
          exp_rdata     = rd_data;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check("wait_idle_bound", 64'(busy), 64'(0));
  endtask

  task automatic drive_wr(input logic [AW+1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] be);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
  endtask

  task automatic wr(input logic [AW+1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] be);
    wait_idle();
    drive_wr(a, d, be);
    step();
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW+1:0] a, output logic [DW-1:0] d, output int lat);
    wait_idle();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!rsp_valid && lat < 8);
    d = rsp_rdata;
  endtask

  task automatic run_clear(input string nm);
    int n = 0;
    int pulses = 0;
    wait_idle();
    clear_start = 1'b1;
    #1;
    check({nm, "_ready_low"}, 64'(req_ready), 64'(0));
    step();
    clear_start = 1'b0;
    while (busy && n < 600) begin
      step();
      n++;
      if (clear_done) pulses++;
    end
    check({nm, "_busy_cycles"}, 64'(n), 64'(WORDS));
    check({nm, "_done_pulses"}, 64'(pulses), 64'(1));
    step();
    check({nm, "_done_drop"}, 64'(clear_done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            lat;
    int            n;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    clear_start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_csb0",   64'(sram_csb0),   64'(1));
    check("rst_web0",   64'(sram_web0),   64'(1));
    check("rst_wmask0", 64'(sram_wmask0), 64'(0));
    check("rst_addr0",  64'(sram_addr0),  64'(0));
    check("rst_rsp",    64'(rsp_valid),   64'(0));
    check("rst_ready",  64'(req_ready),   64'(1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wr(11'h010, 32'hDEAD_BEEF, 4'hF);
    rd(11'h010, d, lat);
    check("rd_deadbeef", 64'(d), 64'(32'hDEAD_BEEF));
    check("rd_latency",  64'(lat), 64'(2));

    wr(11'h020, 32'hFFFF_FFFF, 4'hF);
    wr(11'h020, 32'h0000_0012, 4'h1);
    rd(11'h020, d, lat);
    check("rd_bytemask", 64'(d), 64'(32'hFFFF_FF12));

    wait_idle();
    for (int i = 0; i < 4; i++) begin
      drive_wr(AW'(0) + 11'(4 * i), 32'h1111_1111 * DW'(i + 1), 4'hF);
      #1;
      check("b2b_ready", 64'(req_ready), 64'(1));
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(11'(4 * i), d, lat);
      check("b2b_readback", 64'(d), 64'(32'h1111_1111 * DW'(i + 1)));
    end

    run_clear("clear1");
    rd(11'h000, d, lat);
    check("clr_rd_000", 64'(d), 64'(0));
    rd(11'h7FC, d, lat);
    check("clr_rd_7fc", 64'(d), 64'(0));

    wr(11'h040, 32'hA5A5_A5A5, 4'hF);
    wait_idle();
    clear_start = 1'b1;
    drive_wr(11'h040, 32'h1234_5678, 4'hF);
    #1;
    check("clr_req_ready", 64'(req_ready), 64'(0));
    step();
    check("clr_req_no_write", 64'(sram_csb0), 64'(1));
    clear_start = 1'b0;
    req_valid = 1'b0;
    wait_idle();
    rd(11'h040, d, lat);
    check("clr_req_rd_040", 64'(d), 64'(0));

    // Fill a few words with nonzero data, then abort a clear at word 100.
    wr(11'h190, 32'hCAFE_0100, 4'hF);
    wr(11'h18C, 32'hCAFE_0099, 4'hF);
    wait_idle();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n = 0;
    while (!(sram_csb0 == 1'b0 && sram_addr0 == AW'(100)) && n < 200) begin
      step();
      n++;
    end
    check("abort_at_100", 64'(sram_addr0), 64'(100));
    rst_n = 1'b0;
    #1;
    check("abort_csb0",   64'(sram_csb0),   64'(1));
    check("abort_web0",   64'(sram_web0),   64'(1));
    check("abort_wmask0", 64'(sram_wmask0), 64'(0));
    check("abort_addr0",  64'(sram_addr0),  64'(0));
    check("abort_din0",   64'(sram_din0),   64'(0));
    check("abort_busy",   64'(busy),        64'(0));
    check("abort_done",   64'(clear_done),  64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_hold_done", 64'(clear_done), 64'(0));
    end
    rst_n = 1'b1;
    step();
    rd(11'h190, d, lat);
    check("abort_word100_kept", 64'(d), 64'(32'hCAFE_0100));
    rd(11'h18C, d, lat);
    check("abort_word99_zero", 64'(d), 64'(0));
    wait_idle();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    check("restart_csb0", 64'(sram_csb0),  64'(0));
    check("restart_addr", 64'(sram_addr0), 64'(0));
    wait_idle();

    for (int i = 0; i < 900; i++) begin
      clear_start = ($urandom_range(0, 249) == 0);
      req_valid   = ($urandom_range(0, 9) < 6);
      req_we      = 1'($urandom);
      req_addr    = 11'($urandom_range(0, 63));
      req_wdata   = $urandom;
      req_be      = 4'($urandom);
      if (i == 450) rst_n = 1'b0;
      if (i == 452) rst_n = 1'b1;
      step();
    end
    clear_start = 1'b0;
    req_valid = 1'b0;
    wait_idle();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port0_ctrl.md
SRAM_PORT0_CTRL -- requirements
Module: sram_port0_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 The block SHALL have parameter NUM_WMASKS, default 4, byte-mask width (DATA_WIDTH/8).
REQ-004 The block SHALL have ports as follows:
- clk  in  1  single clock for all logic and the SRAM port-0 clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  NUM_WMASKS  byte enables for writes.
- rsp_valid  out  1  one-cycle read-data pulse.
- rsp_rdata  out  DATA_WIDTH  read data.
- clear_start  in  1  pulse: zero-fill the whole SRAM.
- busy  out  1  controller not idle.
- clear_done  out  1  one-cycle pulse at end of zero-fill.
- sram_csb0  out  1  SRAM chip select, active low.
- sram_web0  out  1  SRAM write enable, active low.
- sram_wmask0  out  NUM_WMASKS  SRAM byte mask.
- sram_addr0  out  ADDR_WIDTH  SRAM word address.
- sram_din0  out  DATA_WIDTH  SRAM write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data.

Function
REQ-005 All sram_* outputs SHALL be driven from flops; the SRAM samples them at the posedge following the one on which they were updated.
REQ-006 FSM states SHALL be IDLE, RD_WAIT, RD_CAP, CLEAR.
REQ-007 req_ready SHALL be combinational: (state==IDLE) && !clear_start.
REQ-008 Word address SHALL be req_addr[ADDR_WIDTH+1:2]; req_addr[1:0] SHALL be ignored.
REQ-009 Write accepted at edge T: on edge T, sram_csb0=0, sram_web0=0, sram_wmask0=req_be, sram_addr0 and sram_din0 loaded; state stays IDLE; no response is generated.
REQ-010 Read accepted at edge T: on edge T, sram_csb0=0, sram_web0=1, sram_wmask0=0, sram_addr0 loaded; state -> RD_WAIT.
REQ-011 RD_WAIT: at edge T+1, sram_csb0=1; state -> RD_CAP.
REQ-012 RD_CAP: at edge T+2, rsp_rdata<=sram_dout0 and rsp_valid<=1 for exactly one cycle; state -> IDLE. Read latency is 2 cycles from acceptance to rsp_valid high.
REQ-013 rsp_rdata SHALL hold its value until the next read capture.
REQ-014 Any IDLE edge with no accepted request or clear SHALL set sram_csb0=1, sram_web0=1, sram_wmask0=0.
REQ-015 Back-to-back writes SHALL be accepted every cycle; a read blocks new requests for 2 cycles.
REQ-016 A clear_start sampled in IDLE SHALL enter CLEAR and reset a word counter to 0. In CLEAR, each cycle SHALL issue a write with sram_addr0=counter, sram_din0=0, and sram_wmask0 all ones, then increment the counter.
REQ-017 After the write to address 2^ADDR_WIDTH-1, the block SHALL pulse clear_done for one cycle and return to IDLE. The counter SHALL not wrap into a second pass.
REQ-018 clear_start outside IDLE SHALL be ignored.
REQ-019 A clear_start and req_valid in the same IDLE cycle SHALL start the clear, and the request SHALL NOT be accepted.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Clock half-period SHALL exceed the SRAM model output DELAY so that sram_dout0 is stable at the RD_CAP edge.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, rsp_valid=0, rsp_rdata=0, clear_done=0, and counter=0.
REQ-023 Reset during CLEAR or a read SHALL abort the operation with no rsp_valid or clear_done; the next clear restarts at address 0.

Verification
REQ-024 Write byte addr 0x010 with data 0xDEADBEEF and be=1111, then read 0x010 -> rsp_valid exactly 2 cycles after read acceptance with rsp_rdata=0xDEADBEEF.
REQ-025 Write 0xFFFFFFFF to 0x020, write 0x00000012 with be=0001 to 0x020, then read -> 0xFFFFFF12.
REQ-026 clear_start -> busy high for 512 cycles, clear_done one pulse; subsequent reads of 0x000 and 0x7FC return 0.
REQ-027 clear_start together with req_valid (write) in IDLE -> req_ready=0, no write to the requested address, clear completes.
REQ-028 Assert rst_n=0 mid-CLEAR at counter=100 -> all outputs at reset values, no clear_done; a new clear_start starts at address 0.
REQ-029 Four back-to-back writes to 0x000, 0x004, 0x008, 0x00C -> req_ready stays high; readback returns all four values.
